// File: rtl/kyber_pkg.sv
// -----------------------------------------------------------------------------
// kyber_pkg
// Shared constants and types for the Kyber polynomial datapath.
//   - Ring constants (modulus, coefficient/word counts, NTT layer count).
//   - Bit positions inside the 10-bit butterfly control bundle bf_ctrl:
//       {flag_add,flag_sub0,flag_sub1,flag_mix0,flag_mix1,flag_m,
//        sel0_a0,sel1_a0,sel_a1,sel_s0}
//   - State encoding of the NTT layer/address scheduler FSM.
// -----------------------------------------------------------------------------
package kyber_pkg;

   localparam int KYBER_Q  = 3329;
   localparam int N_COEF   = 256;
   localparam int N_WORD   = 128;   // two 12-bit coefficients per 24-bit word
   localparam int N_LAYER  = 7;
   localparam int N_BFLY   = 64;    // word-pair butterflies per layer
   localparam int CTRL_W   = 10;

   // bf_ctrl bit positions (MSB first)
   localparam int BF_FLAG_ADD  = 9;
   localparam int BF_FLAG_SUB0 = 8;
   localparam int BF_FLAG_SUB1 = 7;
   localparam int BF_FLAG_MIX0 = 6;
   localparam int BF_FLAG_MIX1 = 5;
   localparam int BF_FLAG_M    = 4;
   localparam int BF_SEL0_A0   = 3;
   localparam int BF_SEL1_A0   = 2;
   localparam int BF_SEL_A1    = 1;
   localparam int BF_SEL_S0    = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/sched_delay.sv
// -----------------------------------------------------------------------------
// sched_delay
// Fixed-depth shift register with synchronous active-high reset. Used to align
// butterfly control with returning RAM data and to delay the write-back
// strobe/addresses by the full read + butterfly latency.
// Ports:
//   clk  in           clock
//   rst  in           synchronous reset, clears every stage
//   d    in  [WIDTH]  value entering the line
//   q    out [WIDTH]  value delayed by DEPTH cycles (DEPTH >= 1)
// -----------------------------------------------------------------------------
module sched_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/ntt_sched.sv
// -----------------------------------------------------------------------------
// ntt_sched
// Layer/address scheduler for the Kyber NTT/INTT, feeding a dual-lane
// butterfly. Each issue cycle emits one RAM word pair plus a twiddle index;
// write-back strobe/addresses follow after RD_LAT+BF_LAT cycles. Each layer
// issues 64 butterflies and then drains the pipeline before the next layer.
//
// Optional build macro: NTT_SCHED_CYCLE_CNT_EN adds the cyc_cnt output
// (cycles spent busy in the last/current run).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, mode          start pulse (ignored unless idle); 0 = NTT, 1 = INTT
//   busy, done           run in progress; one-cycle pulse after last write
//   rd_en, rd_addr_a/b   RAM read strobe and word pair
//   tw_addr              twiddle ROM index
//   bf_ctrl              butterfly flag bundle aligned with read data
//   wr_en, wr_addr_a/b   write-back strobe and destination words
//   cyc_cnt              (macro only) busy-cycle performance probe
// -----------------------------------------------------------------------------
module ntt_sched
   import kyber_pkg::*;
#(
   parameter int                RD_LAT    = 1,
   parameter int                BF_LAT    = 7,
   parameter logic [CTRL_W-1:0] CTRL_NTT  = 10'b0,
   parameter logic [CTRL_W-1:0] CTRL_INTT = 10'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [6:0]        rd_addr_a,
   output logic [6:0]        rd_addr_b,
   output logic [6:0]        tw_addr,
   output logic [CTRL_W-1:0] bf_ctrl,
   output logic              wr_en,
   output logic [6:0]        wr_addr_a,
   output logic [6:0]        wr_addr_b
`ifdef NTT_SCHED_CYCLE_CNT_EN
   ,
   output logic [15:0]       cyc_cnt
`endif
);

   localparam int DRAIN_LEN = RD_LAT + BF_LAT;
   localparam int DW        = $clog2(DRAIN_LEN + 1);

   // Word address of the first element of butterfly b in layer l:
   // distance d = 64>>l, group g = b>>(6-l), offset o = b & (d-1),
   // addr = g*2d + o. 2d is a power of two, so the product is a shift.
   function automatic logic [6:0] word_a(input logic [2:0] l, input logic [5:0] b);
      logic [6:0] bb, d, g;
      bb = {1'b0, b};
      d  = 7'd64 >> l;
      g  = bb >> (3'd6 - l);
      return (g << (3'd7 - l)) | (bb & (d - 7'd1));
   endfunction

   function automatic logic [6:0] word_dist(input logic [2:0] l);
      return 7'd64 >> l;
   endfunction

   // Forward: (1<<l) + g. Inverse: (2<<l) - 1 - g. For l = 6 the term 2<<6
   // is 128, which is 0 modulo 2^7; the 7-bit difference is still exact.
   function automatic logic [6:0] tw_index(input logic inv, input logic [2:0] l,
                                           input logic [5:0] b);
      logic [6:0] g;
      g = {1'b0, b} >> (3'd6 - l);
      if (inv) return (7'd2 << l) - 7'd1 - g;
      else     return (7'd1 << l) + g;
   endfunction

   sched_state_t    state, state_n;
   logic [5:0]      b_cnt, b_n;      // butterfly index within the layer
   logic [2:0]      k_cnt, k_n;      // layer step 0..6 (layer = k or 6-k)
   logic [DW-1:0]   dr_cnt, dr_n;    // drain cycle counter
   logic            mode_q, mode_n;
   logic [2:0]      layer_n;
   logic            issue_n;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         b_cnt  <= '0;
         k_cnt  <= '0;
         dr_cnt <= '0;
         mode_q <= 1'b0;
      end else begin
         state  <= state_n;
         b_cnt  <= b_n;
         k_cnt  <= k_n;
         dr_cnt <= dr_n;
         mode_q <= mode_n;
      end
   end

   // ---------------- next state / decoded outputs ----------------
   always_comb begin
      state_n = state;
      b_n     = b_cnt;
      k_n     = k_cnt;
      dr_n    = dr_cnt;
      mode_n  = mode_q;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_n = ST_ISSUE;
               b_n     = '0;
               k_n     = '0;
               dr_n    = '0;
               mode_n  = mode;
            end
         end
         ST_ISSUE: begin
            busy = 1'b1;
            if (b_cnt == 6'(N_BFLY - 1)) begin
               state_n = ST_DRAIN;
               dr_n    = '0;
            end else begin
               b_n = b_cnt + 6'd1;
            end
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (dr_cnt == DW'(DRAIN_LEN - 1)) begin
               if (k_cnt == 3'(N_LAYER - 1)) begin
                  state_n = ST_DONE;
               end else begin
                  state_n = ST_ISSUE;
                  k_n     = k_cnt + 3'd1;
                  b_n     = '0;
               end
            end else begin
               dr_n = dr_cnt + DW'(1);
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
      issue_n = (state_n == ST_ISSUE);
      layer_n = mode_n ? (3'd6 - k_n) : k_n;
   end

   // Read-side outputs are registered from the next-state view so they are
   // valid in exactly the cycles the FSM sits in ISSUE.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr   <= '0;
      end else begin
         rd_en     <= issue_n;
         rd_addr_a <= issue_n ? word_a(layer_n, b_n) : 7'd0;
         rd_addr_b <= issue_n ? (word_a(layer_n, b_n) + word_dist(layer_n)) : 7'd0;
         tw_addr   <= issue_n ? tw_index(mode_n, layer_n, b_n) : 7'd0;
      end
   end

   // Butterfly flags line up with in0/in1, RD_LAT cycles after the read.
   logic [CTRL_W-1:0] ctrl_in;
   assign ctrl_in = rd_en ? (mode_q ? CTRL_INTT : CTRL_NTT) : '0;

   sched_delay #(.WIDTH(CTRL_W), .DEPTH(RD_LAT)) u_ctrl_dly (
      .clk (clk),
      .rst (rst),
      .d   (ctrl_in),
      .q   (bf_ctrl)
   );

   // Write-back follows the read by the full RAM + butterfly latency.
   logic [14:0] wb_q;

   sched_delay #(.WIDTH(15), .DEPTH(DRAIN_LEN)) u_wb_dly (
      .clk (clk),
      .rst (rst),
      .d   ({rd_en, rd_addr_a, rd_addr_b}),
      .q   (wb_q)
   );

   assign wr_en     = wb_q[14];
   assign wr_addr_a = wb_q[13:7];
   assign wr_addr_b = wb_q[6:0];

`ifdef NTT_SCHED_CYCLE_CNT_EN
   // Cleared on an accepted start; counts busy cycles; holds when idle.
   always_ff @(posedge clk) begin
      if (rst)                           cyc_cnt <= '0;
      else if (state == ST_IDLE && start) cyc_cnt <= '0;
      else if (busy)                     cyc_cnt <= cyc_cnt + 16'd1;
   end
`endif

endmodule
